// File: rtl/pwm_timers.sv
// Timer datapath for one PWM channel: double-buffered period/ON values, saturating down-counters
// and status flags for the upstream control FSM. Define PWM_PRESCALE_EN to add a decrement prescaler.
module pwm_timers #(
  parameter int unsigned PWM_UNIT     = 0,
  parameter int unsigned TIMER_WIDTH  = 16,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   config_wr,
  input  logic [TIMER_WIDTH-1:0] T_period_in,
  input  logic [TIMER_WIDTH-1:0] T_on_in,
  input  logic                   reload_times,
  input  logic                   dec_T_on,
  input  logic                   dec_T_period,
  output logic                   T_on_zero,
  output logic                   T_period_zero,
  output logic                   T_on_MAX,
  output logic                   T_on_MIN,
  output logic                   config_pending,
  output logic [TIMER_WIDTH-1:0] T_on_count,
  output logic [TIMER_WIDTH-1:0] T_period_count
);

  logic [TIMER_WIDTH-1:0] shadow_on_q, shadow_on_d;
  logic [TIMER_WIDTH-1:0] shadow_period_q, shadow_period_d;
  logic [TIMER_WIDTH-1:0] active_on_q, active_on_d;
  logic [TIMER_WIDTH-1:0] active_period_q, active_period_d;
  logic [TIMER_WIDTH-1:0] on_cnt_q, on_cnt_d;
  logic [TIMER_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                   pending_q, pending_d;
  logic                   tick;

`ifdef PWM_PRESCALE_EN
  localparam int unsigned PreW = $clog2(PRESCALE_DIV);

  logic [PreW-1:0] presc_q, presc_d;
  logic            presc_wrap;

  assign presc_wrap = (presc_q == PreW'(PRESCALE_DIV - 1));
  // Decrements are already gated by their request, so the wrap alone is the tick.
  assign tick = presc_wrap;

  always_comb begin
    presc_d = presc_q;
    if (reload_times) begin
      presc_d = '0;
    end else if (dec_T_on || dec_T_period) begin
      presc_d = presc_wrap ? '0 : presc_q + PreW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    shadow_on_d     = shadow_on_q;
    shadow_period_d = shadow_period_q;
    active_on_d     = active_on_q;
    active_period_d = active_period_q;
    on_cnt_d        = on_cnt_q;
    period_cnt_d    = period_cnt_q;
    pending_d       = pending_q;

    if (config_wr) begin
      shadow_on_d     = T_on_in;
      shadow_period_d = T_period_in;
    end

    // A write in the same cycle as a reload keeps pending set: the new values were not loaded.
    if (config_wr) begin
      pending_d = 1'b1;
    end else if (reload_times) begin
      pending_d = 1'b0;
    end

    if (reload_times) begin
      on_cnt_d        = shadow_on_q;
      period_cnt_d    = shadow_period_q;
      active_on_d     = shadow_on_q;
      active_period_d = shadow_period_q;
    end else begin
      if (dec_T_on && tick && (on_cnt_q != '0)) begin
        on_cnt_d = on_cnt_q - TIMER_WIDTH'(1);
      end
      if (dec_T_period && tick && (period_cnt_q != '0)) begin
        period_cnt_d = period_cnt_q - TIMER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_on_q     <= '0;
      shadow_period_q <= '0;
      active_on_q     <= '0;
      active_period_q <= '0;
      on_cnt_q        <= '0;
      period_cnt_q    <= '0;
      pending_q       <= 1'b0;
    end else begin
      shadow_on_q     <= shadow_on_d;
      shadow_period_q <= shadow_period_d;
      active_on_q     <= active_on_d;
      active_period_q <= active_period_d;
      on_cnt_q        <= on_cnt_d;
      period_cnt_q    <= period_cnt_d;
      pending_q       <= pending_d;
    end
  end

  assign T_on_zero      = (on_cnt_q == '0);
  assign T_period_zero  = (period_cnt_q == '0);
  assign T_on_MIN       = (shadow_on_q == '0);
  assign T_on_MAX       = !T_on_MIN && (shadow_on_q >= shadow_period_q);
  assign config_pending = pending_q;
  assign T_on_count     = on_cnt_q;
  assign T_period_count = period_cnt_q;

  // Active copies exist for debug visibility only; the channel index is informational.
  logic unused_dbg;
  assign unused_dbg = ^{active_on_q, active_period_q, PWM_UNIT, PRESCALE_DIV};

endmodule
